// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// master = loader side (sinks the stream, drives the memory bus); slave = environment side.
interface imem_stream_loader_if #(
  parameter int ADDR_W = 6
);
  logic              InValid;
  logic [7:0]        InData;
  logic              InReady;
  logic              WE;
  logic [ADDR_W-1:0] A;
  logic [31:0]       WD;

  modport master (
    input  InValid,
    input  InData,
    output InReady,
    output WE,
    output A,
    output WD
  );

  modport slave (
    output InValid,
    output InData,
    input  InReady,
    input  WE,
    input  A,
    input  WD
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot-time instruction-memory loader: header word N, then N words written from address 0.
// Optional trailing checksum word when LOADER_CHECKSUM_EN is defined.
module imem_stream_loader #(
  parameter int ADDR_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  imem_stream_loader_if.master  bus,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_W:0]       WordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  state_t            state_r, state_s;
  logic [1:0]        byte_cnt_r, byte_cnt_s;
  logic [23:0]       asm_r, asm_s;
  logic [ADDR_W:0]   n_r, n_s;
  logic [ADDR_W:0]   words_r, words_s, words_inc_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] a_r, a_s;
  logic [31:0]       wd_r, wd_s;
  logic              in_ready_r, in_ready_s;
  logic              cpu_hold_r, cpu_hold_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic              accept_s, last_s;
  logic [31:0]       word_s;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_r, sum_s;
`endif

  // Next-state and next-output logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    words_s     = words_r;
    we_s        = 1'b0;
    a_s         = a_r;
    wd_s        = wd_r;
`ifdef LOADER_CHECKSUM_EN
    sum_s       = sum_r;
`endif
    word_s      = {asm_r, bus.InData};
    accept_s    = bus.InValid & in_ready_r;
    last_s      = accept_s & (byte_cnt_r == 2'd3);
    words_inc_s = words_r + (ADDR_W+1)'(1);

    if (accept_s) begin
      byte_cnt_s = byte_cnt_r + 2'd1;
      asm_s      = word_s[23:0];
    end else begin
      byte_cnt_s = byte_cnt_r;
      asm_s      = asm_r;
    end

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_s = S_HDR;
          words_s = {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
          sum_s   = 32'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      S_HDR: begin
        if (last_s) begin
          if (word_s > DEPTH) begin
            state_s = S_ERR;
          end else if (word_s == 32'd0) begin
            state_s = S_FIN;
          end else begin
            n_s     = word_s[ADDR_W:0];
            state_s = S_LOAD;
          end
        end else begin
          state_s = S_HDR;
        end
      end
      S_LOAD: begin
        // The write cycle retires the word; the count only moves once WE has been seen.
        if (we_r) begin
          words_s = words_inc_s;
          if (words_inc_s == n_r) begin
            state_s = S_FIN;
          end else begin
            state_s = S_LOAD;
          end
        end else if (last_s) begin
          we_s = 1'b1;
          a_s  = words_r[ADDR_W-1:0];
          wd_s = word_s;
`ifdef LOADER_CHECKSUM_EN
          sum_s = sum_r + word_s;
`endif
        end else begin
          state_s = S_LOAD;
        end
      end
      S_FIN: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_s) begin
          if (word_s == sum_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = S_FIN;
        end
`else
        state_s = S_DONE;
`endif
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

`ifdef LOADER_CHECKSUM_EN
    in_ready_s = (state_s == S_HDR) | ((state_s == S_LOAD) & ~we_s) | (state_s == S_FIN);
`else
    in_ready_s = (state_s == S_HDR) | ((state_s == S_LOAD) & ~we_s);
`endif
    cpu_hold_s = (state_s != S_DONE);
    done_s     = (state_s == S_DONE);
    error_s    = (state_s == S_ERR);
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      n_r        <= {(ADDR_W+1){1'b0}};
      words_r    <= {(ADDR_W+1){1'b0}};
      we_r       <= 1'b0;
      a_r        <= {ADDR_W{1'b0}};
      wd_r       <= 32'd0;
      in_ready_r <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_r      <= 32'd0;
`endif
    end else begin
      byte_cnt_r <= byte_cnt_s;
      asm_r      <= asm_s;
      n_r        <= n_s;
      words_r    <= words_s;
      we_r       <= we_s;
      a_r        <= a_s;
      wd_r       <= wd_s;
      in_ready_r <= in_ready_s;
      cpu_hold_r <= cpu_hold_s;
      done_r     <= done_s;
      error_r    <= error_s;
`ifdef LOADER_CHECKSUM_EN
      sum_r      <= sum_s;
`endif
    end
  end

  assign bus.InReady  = in_ready_r;
  assign bus.WE       = we_r;
  assign bus.A        = a_r;
  assign bus.WD       = wd_r;
  assign CpuHold      = cpu_hold_r;
  assign Done         = done_r;
  assign Error        = error_r;
  assign WordsLoaded  = words_r;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: expected writes are queued as words are sent
// and checked when WE is observed.
module tb_imem_stream_loader;
  localparam int ADDR_W = 6;
  localparam logic [31:0] P0 = 32'h2001_0005;
  localparam logic [31:0] P1 = 32'h8C02_000D;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd;
  } wr_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              Start = 1'b0;
  logic              CpuHold, Done, Error;
  logic [ADDR_W:0]   WordsLoaded;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   last_we_cyc = 0;
  int   end_cyc = 0;
  int   w0;
  logic mon_en = 1'b0;
  logic we_prev = 1'b0;
  wr_t  sb_q[$];
  wr_t  mon_exp;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_stream_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Start       (Start),
    .bus         (bus),
    .CpuHold     (CpuHold),
    .Done        (Done),
    .Error       (Error),
    .WordsLoaded (WordsLoaded)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory-write monitor: every WE pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (mon_en && bus.WE === 1'b1) begin
      we_count    <= we_count + 1;
      last_we_cyc <= cyc;
      check_eq("we_single_cycle", 32'(we_prev), 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("we_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("we_addr", 32'(bus.A), 32'(mon_exp.a));
        check_eq("we_data", bus.WD, mon_exp.wd);
      end
    end
    we_prev <= mon_en ? bus.WE : 1'b0;
  end

  task automatic start_pulse();
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.InValid = 1'b1;
    bus.InData  = b;
    while (!acc && n < 64) begin
      @(negedge CLK);
      acc = bus.InReady;
      @(posedge CLK); #1;
      Start = 1'b0;
      n++;
    end
    bus.InValid = 1'b0;
    check_eq("byte_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit thr);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if (thr) begin
        repeat ($urandom_range(3, 1)) @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic wait_end(input bit exp_done);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(Done || Error) && n < 64) begin
      @(negedge CLK);
      n++;
    end
    end_cyc = cyc;
    check_eq("done", 32'(Done), 32'(exp_done));
    check_eq("error", 32'(Error), 32'(!exp_done));
    check_eq("cpuhold", 32'(CpuHold), 32'(!exp_done));
    @(posedge CLK); #1;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_inready"}, 32'(bus.InReady), 32'd0);
    check_eq({tag, "_we"}, 32'(bus.WE), 32'd0);
    check_eq({tag, "_a"}, 32'(bus.A), 32'd0);
    check_eq({tag, "_wd"}, bus.WD, 32'd0);
    check_eq({tag, "_cpuhold"}, 32'(CpuHold), 32'd1);
    check_eq({tag, "_done"}, 32'(Done), 32'd0);
    check_eq({tag, "_error"}, 32'(Error), 32'd0);
    check_eq({tag, "_words"}, 32'(WordsLoaded), 32'd0);
  endtask

  task automatic basic_load(input bit thr);
    start_pulse();
    sb_q.push_back({6'd0, P0});
    sb_q.push_back({6'd1, P1});
    send_word(32'd2, thr);
    send_word(P0, thr);
    send_word(P1, thr);
`ifdef LOADER_CHECKSUM_EN
    send_word(P0 + P1, thr);
`endif
    wait_end(1'b1);
    check_eq("words_loaded", 32'(WordsLoaded), 32'd2);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset("por");
    mon_en = 1'b1;
    @(posedge CLK); #1;

    // basic load, InValid held high
    w0 = we_count;
    basic_load(1'b0);
    check_eq("basic_we_count", 32'(we_count - w0), 32'd2);
`ifndef LOADER_CHECKSUM_EN
    check_eq("done_latency", 32'(end_cyc - last_we_cyc), 32'd2);
`endif

    // throttled stream
    w0 = we_count;
    basic_load(1'b1);
    check_eq("throttle_we_count", 32'(we_count - w0), 32'd2);

    // zero header
    w0 = we_count;
    start_pulse();
    send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0, 1'b0);
`endif
    wait_end(1'b1);
    check_eq("zero_we_count", 32'(we_count - w0), 32'd0);
    check_eq("zero_words", 32'(WordsLoaded), 32'd0);

    // overflow header, then recovery
    w0 = we_count;
    start_pulse();
    send_word(32'h0000_0041, 1'b0);
    wait_end(1'b0);
    check_eq("ovf_we_count", 32'(we_count - w0), 32'd0);
    w0 = we_count;
    basic_load(1'b0);
    check_eq("ovf_recover_we", 32'(we_count - w0), 32'd2);

    // restart from DONE, Start pulses during LOAD ignored
    start_pulse();
    @(negedge CLK);
    check_eq("restart_cpuhold", 32'(CpuHold), 32'd1);
    check_eq("restart_done", 32'(Done), 32'd0);
    check_eq("restart_words", 32'(WordsLoaded), 32'd0);
    @(posedge CLK); #1;
    w0 = we_count;
    sb_q.push_back({6'd0, 32'h1111_2222});
    sb_q.push_back({6'd1, 32'hDEAD_BEEF});
    sb_q.push_back({6'd2, 32'h0000_00FF});
    send_word(32'd3, 1'b0);
    send_word(32'h1111_2222, 1'b0);
    Start = 1'b1;
    send_word(32'hDEAD_BEEF, 1'b0);
    Start = 1'b1;
    send_word(32'h0000_00FF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h1111_2222 + 32'hDEAD_BEEF + 32'h0000_00FF, 1'b0);
`endif
    wait_end(1'b1);
    check_eq("restart_we_count", 32'(we_count - w0), 32'd3);
    check_eq("restart_words_end", 32'(WordsLoaded), 32'd3);

    // reset mid-load after the 2nd byte of the first program word
    start_pulse();
    send_word(32'd2, 1'b0);
    send_byte(8'h20);
    send_byte(8'h01);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset("midrst");
    @(posedge CLK); #1;
    w0 = we_count;
    basic_load(1'b0);
    check_eq("midrst_we_count", 32'(we_count - w0), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum
    start_pulse();
    sb_q.push_back({6'd0, P0});
    sb_q.push_back({6'd1, P1});
    send_word(32'd2, 1'b0);
    send_word(P0, 1'b0);
    send_word(P1, 1'b0);
    send_word(P0 + P1 + 32'd1, 1'b0);
    wait_end(1'b0);
`endif

    check_eq("sb_final", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
